// File: rtl/f_table.sv
// ---------------------------------------------------------------------------
// f_table -- storage and response engine for the formant-tracking dynamic
// program.
//
// Holds the F (cost) and B (backpointer) tables, FORMANTS rows by I columns.
// Accepts the F-stage write stream, answers the F-stage read protocol two
// cycles after each request, and offers an independent B-table read port for
// the backtrace stage.
//
// Ports:
//   clk_in        single clock
//   rst_in        asynchronous active-low reset
//   begin_iter    pulse: latch i as the current column, invalidate its rows
//   i             column index sampled with begin_iter
//   iter_done     pulse: current column complete (cols_done saturates at I)
//   k_req, j_req  F-stage request, sampled on every edge
//   f_prev        F(k_req-1, j_req), 0 for k_req==0, all-ones if uncomputed
//   f_old         F(k_req, cur_i), all-ones if row not yet written
//   k_write       row written in column cur_i
//   f_data/b_data values written on output_valid
//   output_valid  write strobe (rows >= FORMANTS are ignored)
//   bt_req        backtrace read strobe
//   bt_k, bt_i    backtrace address (out of range reads as 0)
//   bt_data       B(bt_k, bt_i), valid with bt_valid
//   bt_valid      one-cycle flag two cycles after bt_req
//   cols_done     number of completed columns
//
// Build option:
//   F_TABLE_FWD_EN  when defined, a write on the edge after a request (the
//                   array-read edge) is forwarded into that request's result.
//                   When undefined, such a write is visible only to requests
//                   sampled on or after its own edge.
//
// Pipeline: request register (edge t) -> array read (edge t+1) -> output
// register (edge t+2).
// ---------------------------------------------------------------------------
module f_table #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int FORMANTS  = 5,
    localparam int KW       = $clog2(FORMANTS),
    localparam int IW       = $clog2(I)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 begin_iter,
    input  logic [IW-1:0]        i,
    input  logic                 iter_done,
    input  logic [KW-1:0]        k_req,
    input  logic [IW-1:0]        j_req,
    output logic [BIT_WIDTH-1:0] f_prev,
    output logic [BIT_WIDTH-1:0] f_old,
    input  logic [KW-1:0]        k_write,
    input  logic [BIT_WIDTH-1:0] f_data,
    input  logic [BIT_WIDTH-1:0] b_data,
    input  logic                 output_valid,
    input  logic                 bt_req,
    input  logic [KW-1:0]        bt_k,
    input  logic [IW-1:0]        bt_i,
    output logic [BIT_WIDTH-1:0] bt_data,
    output logic                 bt_valid,
    output logic [IW:0]          cols_done
);

    localparam int DEPTH = FORMANTS * I;
    localparam int AW    = $clog2(DEPTH);

    // Limits widened by one bit so comparisons stay exact for any parameter set.
    localparam logic [KW:0] K_LIM = (KW+1)'(FORMANTS);
    localparam logic [IW:0] I_LIM = (IW+1)'(I);

    // Source of the f_prev result, decided at the array-read stage.
    localparam logic [1:0] SEL_ZERO = 2'd0;  // DP base case, k_req == 0
    localparam logic [1:0] SEL_INF  = 2'd1;  // column not computed yet
    localparam logic [1:0] SEL_DATA = 2'd2;  // array word

    // Row-major flat address: row k, column j.
    function automatic logic [AW-1:0] mem_addr(input logic [KW-1:0] k,
                                               input logic [IW-1:0] j);
        return AW'(k) * AW'(I) + AW'(j);
    endfunction

    // -----------------------------------------------------------------------
    // Storage and column state
    // -----------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] f_mem [DEPTH];
    logic [BIT_WIDTH-1:0] b_mem [DEPTH];

    logic [IW-1:0]       cur_i;
    logic [FORMANTS-1:0] col_vld;

    logic                wr_ok;
    logic [AW-1:0]       wr_addr;
    logic [FORMANTS-1:0] wr_row_mask;

    // A write is dropped when the row is out of range, or when the current
    // column itself is out of range (begin_iter with i >= I).
    always_comb begin
        // NOTE: every signal gets a default before any branch so always_comb
        // never infers a latch.
        wr_ok       = output_valid && ({1'b0, k_write} < K_LIM)
                                   && ({1'b0, cur_i} < I_LIM);
        wr_addr     = wr_ok ? mem_addr(k_write, cur_i) : '0;
        wr_row_mask = '0;
        for (int r = 0; r < FORMANTS; r++) begin
            wr_row_mask[r] = wr_ok && (k_write == KW'(r));
        end
    end

    // begin_iter clears the whole valid vector even if a write hits the same
    // edge: that write lands in the old column, which is no longer current.
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: sequential state is assigned with <= only, so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_in) begin
            cur_i     <= '0;
            col_vld   <= '0;
            cols_done <= '0;
        end else begin
            if (begin_iter) begin
                cur_i   <= i;
                col_vld <= '0;
            end else begin
                col_vld <= col_vld | wr_row_mask;
            end
            if (iter_done && (cols_done != I_LIM)) begin
                cols_done <= cols_done + (IW+1)'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: request registers (edge t)
    // -----------------------------------------------------------------------
    logic [KW-1:0] req_k_q;
    logic [IW-1:0] req_j_q;
    logic          bt_req_q;
    logic [KW-1:0] bt_k_q;
    logic [IW-1:0] bt_i_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            req_k_q  <= '0;
            req_j_q  <= '0;
            bt_req_q <= 1'b0;
            bt_k_q   <= '0;
            bt_i_q   <= '0;
        end else begin
            req_k_q  <= k_req;
            req_j_q  <= j_req;
            bt_req_q <= bt_req;
            bt_k_q   <= bt_k;
            bt_i_q   <= bt_i;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: decode and array read (edge t+1)
    // -----------------------------------------------------------------------
    logic [1:0]    prev_sel_d;
    logic [AW-1:0] prev_addr;
    logic          old_vld_d;
    logic [AW-1:0] old_addr;
    logic          bt_hit_d;
    logic [AW-1:0] bt_addr;
    logic          fwd_prev;
    logic          fwd_old;
    logic          fwd_bt;

    always_comb begin
        prev_sel_d = SEL_DATA;
        if (req_k_q == '0) begin
            prev_sel_d = SEL_ZERO;
        end else if (({1'b0, req_j_q} >= cols_done) ||
                     ({1'b0, req_j_q} >= I_LIM)     ||
                     ({1'b0, req_k_q} >  K_LIM)) begin
            prev_sel_d = SEL_INF;
        end
        // Unused addresses are parked at 0 so the array is never indexed
        // out of range.
        prev_addr = (prev_sel_d == SEL_DATA) ?
                    mem_addr(req_k_q - KW'(1), req_j_q) : '0;

        old_vld_d = 1'b0;
        for (int r = 0; r < FORMANTS; r++) begin
            if (req_k_q == KW'(r)) begin
                old_vld_d = col_vld[r];
            end
        end

        bt_hit_d = bt_req_q && ({1'b0, bt_k_q} < K_LIM)
                            && ({1'b0, bt_i_q} < I_LIM);
        bt_addr  = bt_hit_d ? mem_addr(bt_k_q, bt_i_q) : '0;

`ifdef F_TABLE_FWD_EN
        // The write arriving on the read edge targets (k_write, cur_i); a
        // match overrides the stale array word and, for f_old, the valid bit.
        fwd_prev = wr_ok && (prev_sel_d == SEL_DATA) &&
                   (k_write == req_k_q - KW'(1)) && (cur_i == req_j_q);
        fwd_old  = wr_ok && (k_write == req_k_q);
        fwd_bt   = wr_ok && bt_hit_d && (k_write == bt_k_q) && (cur_i == bt_i_q);
`else
        fwd_prev = 1'b0;
        fwd_old  = 1'b0;
        fwd_bt   = 1'b0;
`endif
        if (fwd_old) begin
            old_vld_d = 1'b1;
        end
        old_addr = old_vld_d ? mem_addr(req_k_q, cur_i) : '0;
    end

    logic [BIT_WIDTH-1:0] prev_rd_q;
    logic [BIT_WIDTH-1:0] old_rd_q;
    logic [BIT_WIDTH-1:0] bt_rd_q;

    // Array write and read share the edge; the read returns the pre-edge word,
    // so a same-edge write is seen only through forwarding.
    always_ff @(posedge clk_in) begin
        // NOTE: the arrays and their read registers have no reset; nothing
        // reaches the outputs unless the reset-cleared select/valid flags
        // below say the word is meaningful.
        if (wr_ok) begin
            f_mem[wr_addr] <= f_data;
            b_mem[wr_addr] <= b_data;
        end
        prev_rd_q <= fwd_prev ? f_data : f_mem[prev_addr];
        old_rd_q  <= fwd_old  ? f_data : f_mem[old_addr];
        bt_rd_q   <= fwd_bt   ? b_data : b_mem[bt_addr];
    end

    logic [1:0] prev_sel_q;
    logic       old_vld_q;
    logic       bt_hit_q;
    logic       bt_req_qq;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev_sel_q <= SEL_ZERO;
            old_vld_q  <= 1'b0;
            bt_hit_q   <= 1'b0;
            bt_req_qq  <= 1'b0;
        end else begin
            prev_sel_q <= prev_sel_d;
            old_vld_q  <= old_vld_d;
            bt_hit_q   <= bt_hit_d;
            bt_req_qq  <= bt_req_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: output registers (edge t+2)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            f_prev   <= '0;
            f_old    <= '1;
            bt_data  <= '0;
            bt_valid <= 1'b0;
        end else begin
            case (prev_sel_q)
                SEL_ZERO: f_prev <= '0;
                SEL_INF:  f_prev <= '1;
                default:  f_prev <= prev_rd_q;
            endcase
            f_old    <= old_vld_q ? old_rd_q : '1;
            bt_data  <= bt_hit_q  ? bt_rd_q  : '0;
            bt_valid <= bt_req_qq;
        end
    end

endmodule

// File: tb/tb_f_table.sv
// ---------------------------------------------------------------------------
// tb_f_table -- self-checking bench for f_table (default build, no
// forwarding).
//
// A table model (2-D arrays, per-row valid flags, column counter) is updated
// once per clock edge from the same stimulus the DUT sees; after the update
// the expected response to the request sampled on that edge is queued and
// compared two edges later.
// ---------------------------------------------------------------------------
module tb_f_table;

    localparam int BW = 32;
    localparam int NI = 160;
    localparam int NF = 5;
    localparam int KW = $clog2(NF);
    localparam int IW = $clog2(NI);
    localparam logic [BW-1:0] INF = '1;

    logic          clk_in;
    logic          rst_in;
    logic          begin_iter;
    logic [IW-1:0] i;
    logic          iter_done;
    logic [KW-1:0] k_req;
    logic [IW-1:0] j_req;
    logic [BW-1:0] f_prev;
    logic [BW-1:0] f_old;
    logic [KW-1:0] k_write;
    logic [BW-1:0] f_data;
    logic [BW-1:0] b_data;
    logic          output_valid;
    logic          bt_req;
    logic [KW-1:0] bt_k;
    logic [IW-1:0] bt_i;
    logic [BW-1:0] bt_data;
    logic          bt_valid;
    logic [IW:0]   cols_done;

    f_table #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(NF)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .begin_iter   (begin_iter),
        .i            (i),
        .iter_done    (iter_done),
        .k_req        (k_req),
        .j_req        (j_req),
        .f_prev       (f_prev),
        .f_old        (f_old),
        .k_write      (k_write),
        .f_data       (f_data),
        .b_data       (b_data),
        .output_valid (output_valid),
        .bt_req       (bt_req),
        .bt_k         (bt_k),
        .bt_i         (bt_i),
        .bt_data      (bt_data),
        .bt_valid     (bt_valid),
        .cols_done    (cols_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    logic [BW-1:0] m_f  [NF][NI];
    logic [BW-1:0] m_b  [NF][NI];
    bit            m_fw [NF][NI];
    bit            m_bw [NF][NI];
    bit            m_vld [NF];
    int            m_cur_i;
    int            m_cols;

    typedef struct {
        logic [BW-1:0] prev;
        logic [BW-1:0] old;
        logic [BW-1:0] bt;
        logic          btv;
        bit            prev_chk;
        bit            bt_chk;
    } exp_t;

    exp_t exp_q [$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs,
                         input logic [BW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t reset_entry();
        exp_t e;
        e.prev = '0; e.old = INF; e.bt = '0; e.btv = 1'b0;
        e.prev_chk = 1'b1; e.bt_chk = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        foreach (m_fw[r, c]) begin
            m_fw[r][c] = 1'b0;
            m_bw[r][c] = 1'b0;
        end
        foreach (m_vld[r]) m_vld[r] = 1'b0;
        m_cur_i = 0;
        m_cols  = 0;
        exp_q.delete();
        // Two edges after release still show reset values.
        exp_q.push_back(reset_entry());
        exp_q.push_back(reset_entry());
    endtask

    // Apply one edge's controls to the model, then queue the expected
    // response for the request sampled on that edge.
    task automatic model_edge();
        exp_t e;
        int kw, kr, jr, bk, bi;
        kw = int'(k_write);
        if (output_valid && kw < NF) begin
            m_f[kw][m_cur_i]  = f_data;
            m_b[kw][m_cur_i]  = b_data;
            m_fw[kw][m_cur_i] = 1'b1;
            m_bw[kw][m_cur_i] = 1'b1;
            if (!begin_iter) m_vld[kw] = 1'b1;
        end
        if (begin_iter) begin
            m_cur_i = int'(i);
            foreach (m_vld[r]) m_vld[r] = 1'b0;
        end
        if (iter_done && m_cols < NI) m_cols++;

        kr = int'(k_req);
        jr = int'(j_req);
        e.prev_chk = 1'b1;
        if (kr == 0)                     e.prev = '0;
        else if (jr >= m_cols || jr >= NI) e.prev = INF;
        else if (m_fw[kr-1][jr])         e.prev = m_f[kr-1][jr];
        else begin
            e.prev = '0;
            e.prev_chk = 1'b0;   // never-written word: contents undefined
        end
        e.old = m_vld[kr] ? m_f[kr][m_cur_i] : INF;

        bk = int'(bt_k);
        bi = int'(bt_i);
        e.btv    = bt_req;
        e.bt_chk = 1'b1;
        e.bt     = '0;
        if (bt_req && bk < NF && bi < NI) begin
            if (m_bw[bk][bi]) e.bt = m_b[bk][bi];
            else              e.bt_chk = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // One clock: model update at the edge, compare 1 time unit later, then
    // drop the single-cycle strobes.
    task automatic step();
        exp_t e;
        @(posedge clk_in);
        model_edge();
        #1;
        check("cols_done", BW'(cols_done), BW'(m_cols));
        while (exp_q.size() > 2) begin
            e = exp_q.pop_front();
            if (e.prev_chk) check("f_prev", f_prev, e.prev);
            check("f_old", f_old, e.old);
            if (e.bt_chk) check("bt_data", bt_data, e.bt);
            check("bt_valid", BW'(bt_valid), BW'(e.btv));
        end
        begin_iter   = 1'b0;
        iter_done    = 1'b0;
        output_valid = 1'b0;
        bt_req       = 1'b0;
    endtask

    task automatic apply_reset();
        rst_in       = 1'b0;
        begin_iter   = 1'b0;
        iter_done    = 1'b0;
        output_valid = 1'b0;
        bt_req       = 1'b0;
        #1;
        check("rst_f_prev", f_prev, '0);
        check("rst_f_old", f_old, INF);
        check("rst_bt_data", bt_data, '0);
        check("rst_bt_valid", BW'(bt_valid), '0);
        check("rst_cols_done", BW'(cols_done), '0);
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_hold_f_old", f_old, INF);
        check("rst_hold_bt_valid", BW'(bt_valid), '0);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_in       = 1'b1;
        begin_iter   = 1'b0;
        i            = '0;
        iter_done    = 1'b0;
        k_req        = '0;
        j_req        = '0;
        k_write      = '0;
        f_data       = '0;
        b_data       = '0;
        output_valid = 1'b0;
        bt_req       = 1'b0;
        bt_k         = '0;
        bt_i         = '0;
        #2;
        apply_reset();

        // Nothing computed yet: both results infinite, no backtrace valid.
        k_req = 3'd2; j_req = 8'd0; step();
        step(); step();

        // Column 0 setup, then the base case and a real predecessor.
        begin_iter = 1'b1; i = 8'd0; step();
        output_valid = 1'b1; k_write = 3'd1; f_data = 32'h10; b_data = 32'h3; step();
        iter_done = 1'b1; step();
        begin_iter = 1'b1; i = 8'd1; step();
        k_req = 3'd2; j_req = 8'd0; step();
        k_req = 3'd0; step();
        step(); step();

        // Write one edge after a request for the same row.
        k_req = 3'd3; j_req = 8'd0; step();
        output_valid = 1'b1; k_write = 3'd3; f_data = 32'h55; b_data = 32'h77; step();
        step(); step();

        // Back-to-back requests, one result per cycle in order.
        for (int k = 1; k <= 4; k++) begin
            k_req = KW'(k); j_req = 8'd0; step();
        end
        step(); step();

        // begin_iter and a write on the same edge: write lands in column 1.
        begin_iter = 1'b1; i = 8'd5;
        output_valid = 1'b1; k_write = 3'd2; f_data = 32'hAB; b_data = 32'hCD; step();
        k_req = 3'd2; bt_req = 1'b1; bt_k = 3'd2; bt_i = 8'd1; step();
        bt_req = 1'b1; bt_k = 3'd6; bt_i = 8'd1; step();
        bt_req = 1'b1; bt_k = 3'd0; bt_i = 8'd200; step();
        output_valid = 1'b1; k_write = 3'd7; f_data = 32'hDEAD; step();
        step(); step();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            begin_iter   = ($urandom_range(0, 15) == 0);
            i            = IW'($urandom_range(0, NI-1));
            iter_done    = ($urandom_range(0, 11) == 0);
            output_valid = ($urandom_range(0, 1) == 1);
            k_write      = KW'($urandom_range(0, 6));
            f_data       = $urandom;
            b_data       = $urandom;
            k_req        = KW'($urandom_range(0, NF-1));
            if ($urandom_range(0, 9) == 0) j_req = IW'($urandom_range(NI, 255));
            else j_req = IW'($urandom_range(0, (m_cols < NI) ? m_cols : NI-1));
            bt_req       = ($urandom_range(0, 2) == 0);
            bt_k         = KW'($urandom_range(0, 6));
            bt_i         = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(NI, 255))
                                                        : IW'(m_cur_i);
            step();
        end

        // Drive cols_done past I to exercise saturation.
        for (int n = 0; n < NI + 10; n++) begin
            iter_done    = 1'b1;
            output_valid = ($urandom_range(0, 1) == 1);
            k_write      = KW'($urandom_range(0, NF-1));
            f_data       = $urandom;
            b_data       = $urandom;
            k_req        = KW'($urandom_range(1, NF-1));
            j_req        = IW'($urandom_range(0, 255));
            step();
        end
        k_req = 3'd1; j_req = 8'd159; step();
        j_req = 8'd200; step();
        step(); step();

        // Reset with requests in flight.
        k_req = 3'd4; j_req = 8'd3; bt_req = 1'b1; bt_k = 3'd1; bt_i = 8'd0; step();
        bt_req = 1'b1; step();
        apply_reset();
        for (int n = 0; n < 4; n++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
